// File: rtl/adc_in_capture.sv
// ADC receive capture: format conversion, trigger range gate, FWFT buffer, I/Q valid/ready stream.
// Input to output is 2 cycles when the buffer is empty. With out_ready low the buffer fills, and further capture samples are dropped (sticky overflow).
module adc_in_capture #(
    parameter int ADC_BITS   = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SW_RF,
    input  logic [31:0] ADC_DATA,
    input  logic        adc_valid,
    input  logic        fmt_ob,
    input  logic        trig,
    input  logic [15:0] cfg_delay,
    input  logic [15:0] cfg_num,
    output logic [15:0] ADC_DATA_I,
    output logic [15:0] ADC_DATA_Q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LSB_MASK = 16'((32'd1 << (16 - ADC_BITS)) - 32'd1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, CAPT} state_t;

    function automatic logic [15:0] conv(input logic [15:0] h, input logic ob);
        conv = {h[15] ^ ob, h[14:0]} & ~LSB_MASK;
    endfunction

    logic [15:0] in_i_q, in_i_d, in_q_q, in_q_d;
    logic        in_vld_q, in_vld_d;
    state_t      state_q, state_d;
    logic [15:0] dly_q, dly_d, num_q, num_d, cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [32:0] hold_q, hold_d;
    logic [15:0] frame_q, frame_d;
    logic [32:0] mem_q [FIFO_DEPTH];

    logic [AW:0] fill;
    logic        empty, full, pop, push_en;
    logic [32:0] push_dat, head;

    always_comb begin
        in_i_d   = conv(ADC_DATA[15:0], fmt_ob);
        in_q_d   = conv(ADC_DATA[31:16], fmt_ob);
        in_vld_d = adc_valid;
        state_d  = state_q;
        dly_d    = dly_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        hold_d   = hold_q;
        frame_d  = frame_q;
        fill     = wr_q - rd_q;
        empty    = (wr_q == rd_q);
        full     = (fill == FULL_CNT);
        head     = mem_q[rd_q[AW-1:0]];
        pop      = !empty && out_ready;
        push_en  = 1'b0;
        push_dat = {1'b0, in_q_q, in_i_q};

        case (state_q)
            IDLE: begin
                if (trig && SW_RF && cfg_num != 16'd0) begin
                    dly_d   = cfg_delay;
                    num_d   = cfg_num;
                    cnt_d   = 16'd0;
                    ovf_d   = 1'b0;
                    state_d = (cfg_delay == 16'd0) ? CAPT : DELAY;
                end
            end
            DELAY: begin
                if (in_vld_q) begin
                    dly_d = dly_q - 16'd1;
                    if (dly_q == 16'd1) state_d = CAPT;
                end
            end
            CAPT: begin
                if (in_vld_q) begin
                    cnt_d       = cnt_q + 16'd1;
                    push_dat[32] = (cnt_q == num_q - 16'd1);
                    // A simultaneous pop frees a slot, so a full buffer still accepts.
                    if (!full || pop) push_en = 1'b1;
                    else              ovf_d   = 1'b1;
                    if (push_dat[32]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rd_d   = rd_q + 1'b1;
            hold_d = head;
            if (head[32]) frame_d = frame_q + 16'd1;
        end
        if (push_en) wr_d = wr_q + 1'b1;

        // RF disable aborts the frame: flush without counting or emitting anything.
        if (!SW_RF) begin
            state_d = IDLE;
            push_en = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            hold_d  = hold_q;
            frame_d = frame_q;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_i_q   <= '0;
            in_q_q   <= '0;
            in_vld_q <= 1'b0;
            state_q  <= IDLE;
            dly_q    <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            hold_q   <= '0;
            frame_q  <= '0;
        end else begin
            in_i_q   <= in_i_d;
            in_q_q   <= in_q_d;
            in_vld_q <= in_vld_d;
            state_q  <= state_d;
            dly_q    <= dly_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            hold_q   <= hold_d;
            frame_q  <= frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_en) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

    // When empty the outputs show the last sample handed downstream.
    assign out_valid  = !empty;
    assign ADC_DATA_I = empty ? hold_q[15:0]  : head[15:0];
    assign ADC_DATA_Q = empty ? hold_q[31:16] : head[31:16];
    assign out_last   = empty ? hold_q[32]    : head[32];
    assign busy       = (state_q != IDLE);
    assign overflow   = ovf_q;
    assign frame_cnt  = frame_q;
endmodule

// File: tb/tb_adc_in_capture.sv
// Bench for adc_in_capture: vector table plus directed sequences, outputs checked against a queue of expected samples.
module tb_adc_in_capture;
    logic        clk = 1'b0;
    logic        rst_n, SW_RF, adc_valid, fmt_ob, trig, out_ready;
    logic [31:0] ADC_DATA;
    logic [15:0] cfg_delay, cfg_num;
    logic [15:0] ADC_DATA_I, ADC_DATA_Q, frame_cnt;
    logic        out_valid, out_last, busy, overflow;

    int nchk = 0;
    int npass = 0;
    int hs_cnt = 0;
    logic [32:0] sbq [$];

    typedef struct {
        logic        fmt;
        logic [15:0] i, q, ei, eq;
    } vec_t;
    vec_t tbl [6];

    adc_in_capture #(.ADC_BITS(12), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .SW_RF(SW_RF), .ADC_DATA(ADC_DATA),
        .adc_valid(adc_valid), .fmt_ob(fmt_ob), .trig(trig),
        .cfg_delay(cfg_delay), .cfg_num(cfg_num),
        .ADC_DATA_I(ADC_DATA_I), .ADC_DATA_Q(ADC_DATA_Q),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] model_fmt(input logic ob, input logic [15:0] h);
        logic [15:0] r;
        r = h;
        r[15] = h[15] ^ ob;
        return r & 16'hFFF0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] iv, input logic [15:0] qv, input logic t);
        ADC_DATA  = {qv, iv};
        adc_valid = 1'b1;
        trig      = t;
        tick();
        trig      = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && (sbq.size() != 0 || out_valid); i++) tick();
        check(name, 48'(sbq.size()), 48'd0);
        adc_valid = 1'b0;
    endtask

    task automatic run_table(input int first, input int n);
        cfg_delay = 16'd0;
        cfg_num   = 16'(n);
        for (int k = 0; k < n; k++) begin
            if (n >= 3 && k == 1) check("lat_not_yet", 48'(out_valid), 48'd0);
            if (n >= 3 && k == 2) begin
                check("lat_valid_n2", 48'(out_valid), 48'd1);
                check("lat_data_n2", {ADC_DATA_Q, ADC_DATA_I}, {tbl[first].eq, tbl[first].ei});
            end
            fmt_ob = tbl[first+k].fmt;
            sbq.push_back({(k == n - 1), tbl[first+k].eq, tbl[first+k].ei});
            drive(tbl[first+k].i, tbl[first+k].q, (k == 0));
        end
        adc_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_cnt++;
            if (sbq.size() == 0) check("unexpected_out", {out_last, ADC_DATA_Q, ADC_DATA_I}, 48'hEEEEEEEEEEEE);
            else check("sample", {out_last, ADC_DATA_Q, ADC_DATA_I}, 48'(sbq.pop_front()));
        end
    end

    initial begin
        logic [15:0] iv, qv;
        tbl[0] = '{1'b1, 16'h8000, 16'h7FF0, 16'h0000, 16'hFFF0};
        tbl[1] = '{1'b1, 16'hFFF0, 16'h0000, 16'h7FF0, 16'h8000};
        tbl[2] = '{1'b1, 16'h0000, 16'hFFF0, 16'h8000, 16'h7FF0};
        tbl[3] = '{1'b1, 16'h7FF0, 16'h8000, 16'hFFF0, 16'h0000};
        tbl[4] = '{1'b0, 16'h123F, 16'h800F, 16'h1230, 16'h8000};
        tbl[5] = '{1'b0, 16'h0001, 16'h7FFF, 16'h0000, 16'h7FF0};

        rst_n = 1'b0; SW_RF = 1'b1; adc_valid = 1'b0; fmt_ob = 1'b0; trig = 1'b0;
        out_ready = 1'b1; ADC_DATA = '0; cfg_delay = '0; cfg_num = '0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_valid", 48'(out_valid), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_ovf", 48'(overflow), 48'd0);
        check("rst_data", {out_last, ADC_DATA_Q, ADC_DATA_I, frame_cnt}, 48'd0);
        tick();

        // Offset-binary frame, then two's complement truncation frame.
        run_table(0, 4);
        wait_drain("fmt_drain");
        check("fmt_frames", 48'(frame_cnt), 48'd1);
        run_table(4, 2);
        wait_drain("trunc_drain");
        check("trunc_frames", 48'(frame_cnt), 48'd2);

        // Delay gating: skip 3, capture 2 of a ramp.
        fmt_ob = 1'b0; cfg_delay = 16'd3; cfg_num = 16'd2;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("dly_busy_%0d", k), 48'(busy), 48'((k >= 1 && k <= 5) ? 1 : 0));
            iv = 16'(k * 16);
            qv = 16'(16'h4000 + k * 32);
            if (k >= 3 && k < 5) sbq.push_back({(k == 4), model_fmt(1'b0, qv), model_fmt(1'b0, iv)});
            drive(iv, qv, (k == 0));
        end
        adc_valid = 1'b0;
        wait_drain("dly_drain");
        check("dly_frames", 48'(frame_cnt), 48'd3);

        // Backpressure: 20 samples into 16 slots.
        out_ready = 1'b0; cfg_delay = 16'd0; cfg_num = 16'd20; hs_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            iv = 16'(16'h0100 + k * 16);
            qv = 16'(16'h5000 + k * 16);
            if (k < 16) sbq.push_back({1'b0, qv, iv});
            drive(iv, qv, (k == 0));
        end
        adc_valid = 1'b0;
        repeat (4) tick();
        check("bp_valid", 48'(out_valid), 48'd1);
        check("bp_ovf", 48'(overflow), 48'd1);
        check("bp_busy", 48'(busy), 48'd0);
        repeat (2) tick();
        check("bp_hold", {out_last, ADC_DATA_Q, ADC_DATA_I}, {1'b0, 16'h5000, 16'h0100});
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_count", 48'(hs_cnt), 48'd16);
        check("bp_frames", 48'(frame_cnt), 48'd3);
        check("bp_ovf_sticky", 48'(overflow), 48'd1);
        cfg_num = 16'd1;
        sbq.push_back({1'b1, 16'h6000, 16'h0770});
        drive(16'h0770, 16'h6000, 1'b1);
        adc_valid = 1'b0;
        check("ovf_cleared", 48'(overflow), 48'd0);
        wait_drain("one_drain");
        check("one_frames", 48'(frame_cnt), 48'd4);

        // Abort after 5 of 10 samples.
        out_ready = 1'b0; cfg_num = 16'd10;
        for (int k = 0; k < 5; k++) drive(16'(k * 16), 16'h0010, (k == 0));
        adc_valid = 1'b0;
        tick();
        check("abort_pre_valid", 48'(out_valid), 48'd1);
        check("abort_pre_busy", 48'(busy), 48'd1);
        SW_RF = 1'b0;
        tick();
        check("abort_valid", 48'(out_valid), 48'd0);
        check("abort_busy", 48'(busy), 48'd0);
        check("abort_frames", 48'(frame_cnt), 48'd4);
        SW_RF = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        check("abort_no_resid", 48'(out_valid), 48'd0);
        hs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            iv = 16'(16'h0A00 + k * 16);
            sbq.push_back({(k == 9), 16'h1110, iv});
            drive(iv, 16'h1110, (k == 0));
        end
        adc_valid = 1'b0;
        wait_drain("refr_drain");
        check("refr_count", 48'(hs_cnt), 48'd10);
        check("refr_frames", 48'(frame_cnt), 48'd5);

        // Retrigger during capture is ignored, as is cfg_num=0.
        cfg_num = 16'd4; hs_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            iv = 16'(16'h2000 + k * 16);
            qv = 16'(16'h3000 + k * 16);
            if (k < 4) sbq.push_back({(k == 3), qv, iv});
            drive(iv, qv, (k == 0 || k == 2));
        end
        adc_valid = 1'b0;
        wait_drain("retrig_drain");
        check("retrig_count", 48'(hs_cnt), 48'd4);
        check("retrig_frames", 48'(frame_cnt), 48'd6);
        check("retrig_busy", 48'(busy), 48'd0);
        cfg_num = 16'd0;
        drive(16'h0F00, 16'h0F00, 1'b1);
        adc_valid = 1'b0;
        check("num0_busy", 48'(busy), 48'd0);
        repeat (3) tick();
        check("num0_valid", 48'(out_valid), 48'd0);
        check("num0_frames", 48'(frame_cnt), 48'd6);

        // Reset in the middle of a capture.
        out_ready = 1'b0; cfg_num = 16'd8;
        for (int k = 0; k < 4; k++) drive(16'h0440, 16'h0550, (k == 0));
        adc_valid = 1'b0;
        check("mid_busy", 48'(busy), 48'd1);
        rst_n = 1'b0;
        tick();
        check("rst2_flags", {out_valid, out_last, busy, overflow}, 48'd0);
        check("rst2_data", {ADC_DATA_Q, ADC_DATA_I, frame_cnt}, 48'd0);
        rst_n = 1'b1;
        sbq.delete();
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/adc_in_capture.md
Name: adc_in_capture

Overview:
Receive-side counterpart of the DAC output path. Takes the 32-bit word from the ADC input deserializer (Q in [31:16], I in [15:0]) and converts its format. Range-gates it against a radar trigger (delay, then N samples). Buffers the gated samples in a small first-word-fall-through (FWFT) FIFO and delivers them as I/Q samples over a valid/ready stream to the downstream pulse-processing chain.

Parameters:
ADC_BITS, 12, significant ADC bits, left-justified in each 16-bit half; the lower 16-ADC_BITS bits are forced to 0.
FIFO_DEPTH, 16, output buffer depth in samples; power of 2, minimum 4.

Ports:
clk  in  1  sample clock, same domain as the DAC path.
rst_n  in  1  reset; one clock; synchronous, active-low.
SW_RF  in  1  RF enable; 0 aborts and holds the block idle.
ADC_DATA  in  32  deserialized word: [31:16] Q, [15:0] I.
adc_valid  in  1  ADC_DATA qualifier.
fmt_ob  in  1  1 = offset-binary input, 0 = two's complement.
trig  in  1  pulse-start strobe, single cycle.
cfg_delay  in  16  valid samples to skip after trig.
cfg_num  in  16  samples to capture per frame.
ADC_DATA_I  out  16  I sample, two's complement.
ADC_DATA_Q  out  16  Q sample, two's complement.
out_valid  out  1  sample available.
out_ready  in  1  downstream accepts.
out_last  out  1  marks the final sample of a frame.
busy  out  1  state is not IDLE.
overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
frame_cnt  out  16  completed frames, wraps at 0xFFFF.

Behaviour:
- Reset (rst_n=0 at clk edge) clears:
  - state to IDLE, FIFO empty;
  - out_valid, out_last, busy, overflow to 0;
  - ADC_DATA_I, ADC_DATA_Q, frame_cnt to 0.
- Input stage, registered, 1 cycle:
  - If fmt_ob=1, invert bit 15 of each half.
  - Zero bits [15-ADC_BITS:0] of each half.
  - adc_valid is delayed alongside the data.
- FSM states are IDLE, DELAY and CAPT.
- IDLE:
  - Enters DELAY on trig & SW_RF & cfg_num!=0.
  - On that cycle it latches cfg_delay and cfg_num and clears overflow.
  - If the latched delay is 0, it enters CAPT directly.
  - A trig with cfg_num=0 is ignored: no state change, frame_cnt unchanged.
- DELAY:
  - Decrements the delay count on each registered valid sample. Those samples are discarded.
  - Enters CAPT when the count reaches 0. The next valid sample is capture sample 0.
- CAPT:
  - Each registered valid sample is pushed to the FIFO with a last bit, set on sample cfg_num-1.
  - After pushing the last sample, returns to IDLE.
- trig outside IDLE is ignored; no retrigger.
- SW_RF=0 in any state:
  - state goes to IDLE next cycle;
  - FIFO is flushed;
  - out_valid=0 next cycle;
  - no out_last is emitted for the aborted frame;
  - frame_cnt is unchanged.
- FIFO full when a CAPT sample arrives:
  - The sample is dropped and overflow is set.
  - The capture count still advances, so the frame still terminates.
  - If the dropped sample was the last one, that frame produces no out_last.
- FIFO is FWFT. out_valid = not empty.
  - Transfer happens on out_valid & out_ready.
  - ADC_DATA_I/Q and out_last are held stable while out_valid & !out_ready.
  - Push and pop in the same cycle while full is legal; the push is not dropped.
- Latency:
  - A sample presented on ADC_DATA at cycle n appears at the output at cycle n+2 when the FIFO is empty.
  - Full throughput: 1 sample per cycle.
- frame_cnt increments on a handshake with out_last=1.
- Outputs hold their last value when out_valid=0.

Test Plan:
- Offset-binary format: fmt_ob=1, cfg_delay=0, cfg_num=4, ADC_DATA I = 0x8000, 0xFFF0, 0x0000, 0x7FF0, with matching Q values.
  - Required: I out = 0x0000, 0x7FF0, 0x8000, 0xFFF0.
  - out_last on the 4th sample only; frame_cnt=1.
  - First output at trigger-aligned sample +2 cycles.
- Delay gating: cfg_delay=3, cfg_num=2, input ramp I=0x0010·k.
  - Required: outputs 0x0030, 0x0040.
  - busy high from trig+1 until the last push.
- ADC_BITS truncation: input I=0x123F with ADC_BITS=12 and fmt_ob=0.
  - Required: output 0x1230.
- Backpressure and overflow: out_ready=0, cfg_num=20, FIFO_DEPTH=16.
  - Required: 16 samples retained, overflow=1, no out_last.
  - After out_ready=1: exactly 16 samples drain in order.
  - The next trig clears overflow.
- Abort: SW_RF dropped after 5 of 10 samples.
  - Required: out_valid=0 next cycle, state IDLE, frame_cnt unchanged.
  - A subsequent trig captures a full frame.
- Ignored triggers: trig during CAPT, and trig with cfg_num=0.
  - Required: no state change, frame count unchanged.
- Reset: rst_n=0 mid-CAPT.
  - Required: all outputs 0 after the following edge.
